slice_stream_ctrl: RTL
======================

Name: slice_stream_ctrl

Overview:
- Slice sequencer that sits in front of the column-parity core (colParity_top).
- Buffers one full 64-slice state (64 x 25-bit words) written by the host.
- Streams (current, previous) slice pairs into the core one slice at a time, with a per-slice start/ready handshake.
- Captures each core result into a result buffer that the host reads back after completion.

Parameters:
- WIDTH, 25, slice width in bits (5x5 lanes).
- DEPTH, 64, number of slices per state.
- ADDR_W, 6, index width; log2(DEPTH).
- TIMEOUT, 1024, watchdog limit in cycles (used only with SLICE_WATCHDOG_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  host write strobe; writes wr_data to the next slice slot.
- wr_data  input  WIDTH  slice word from the host.
- clr  input  1  clears the load pointer and the full/done/overflow/err flags.
- go  input  1  starts a processing pass.
- full  output  1  all DEPTH slices loaded.
- busy  output  1  pass in progress.
- done  output  1  pass finished; level signal.
- overflow  output  1  sticky; an illegal write was dropped.
- err  output  1  sticky; watchdog expired.
- core_start  output  1  one-cycle start pulse to the core.
- core_curr  output  WIDTH  slice k.
- core_pre  output  WIDTH  slice k-1, with wrap-around (slice 63 for k=0).
- core_ready  input  1  core result valid.
- core_out  input  WIDTH  core result for slice k.
- rd_addr  input  ADDR_W  result read index.
- rd_data  output  WIDTH  result word; registered.

Behaviour:
- Reset:
  - All outputs, state, pointers and flags go to 0.
  - Buffer contents are undefined after reset and need not be cleared.
- Load:
  - In IDLE or DONE with full=0, wr_en writes in_mem[wr_ptr] and increments wr_ptr.
  - full rises on the cycle after the 64th write.
  - wr_en while full=1 or busy=1 is dropped and sets overflow.
- clr:
  - Honoured only when busy=0.
  - Clears wr_ptr, full, done, overflow and err; returns to IDLE.
  - If clr and go are asserted in the same cycle, clr wins.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: go && full goes to ISSUE, with k=0 and busy=1. go with full=0 is ignored.
  - ISSUE (1 cycle): drive core_curr=in_mem[k] and core_pre=in_mem[(k-1) mod 64] as registered values. Pulse core_start=1, then go to WAIT. core_curr and core_pre hold stable until the next ISSUE.
  - WAIT: core_ready is ignored in the first WAIT cycle, to guard against a level-held ready left over from the previous slice. From the second WAIT cycle on, core_ready=1 writes res_mem[k]=core_out.
    - If k==63: go to DONE.
    - Otherwise: k+1, then go to ISSUE.
  - DONE: done=1, busy=0. go with full=1 starts a new pass over the same input (done drops in the ISSUE cycle). clr goes to IDLE.
- Minimum per-slice cost is 3 cycles (ISSUE, the blind WAIT cycle, the capture cycle).
- Read port: rd_data = res_mem[rd_addr] registered, 1-cycle latency, readable in any state. Reading during a pass returns the result of the previous pass for slots not yet overwritten.
- Index arithmetic is modulo DEPTH; k and wr_ptr wrap without carry side effects.
- Asserting rst mid-pass aborts immediately: outputs go to 0 and the FSM returns to IDLE. The host must reload the buffer before the next go.

Optional Feature:
- SLICE_WATCHDOG_EN defined:
  - A counter runs while in WAIT and restarts on each ISSUE.
  - If it reaches TIMEOUT without a capture: set err=1, go to DONE (done=1).
  - Unprocessed res_mem slots keep their previous contents.
- Not defined:
  - WAIT blocks indefinitely.
  - err is tied to 0 and no counter logic is present.

Test Plan:
- Echo-model core (core_out=curr^pre, ready pulsed 3 cycles after core_start); load in_mem[k]=k, go -> done=1; rd_addr=0 gives 63 (0^63), rd_addr=5 gives 1, rd_addr=63 gives 1; exactly 64 core_start pulses observed.
- Load only 40 words, go -> no core_start, busy stays 0; write the 24 remaining words -> full=1; go -> pass completes.
- After full, one extra wr_en (any data) -> overflow=1 and in_mem unchanged (slice 0 still reads as curr on the first ISSUE); clr -> full=0, overflow=0.
- Core holds core_ready permanently high -> first-cycle guard gives exactly one capture per slice; results match the echo model; 192 cycles from ISSUE of slice 0 to done.
- Assert rst at slice 20 of a pass -> all outputs 0 next edge; reload 64 words, go -> full correct pass.
- With SLICE_WATCHDOG_EN and TIMEOUT=16: core never returns ready on slice 7 -> err=1 and done=1 seventeen cycles after that ISSUE; res_mem[0..6] valid.

Source files
------------

// File: rtl/slice_stream_ctrl.sv
// Slice sequencer: buffers one DEPTH-slice state, streams (curr, prev) slice pairs into the
// column-parity core and collects the results. Optional watchdog: define SLICE_WATCHDOG_EN.
module slice_stream_ctrl #(
    parameter int WIDTH   = 25,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr,
    input  logic              go,
    output logic              full,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              err,
    output logic              core_start,
    output logic [WIDTH-1:0]  core_curr,
    output logic [WIDTH-1:0]  core_pre,
    input  logic              core_ready,
    input  logic [WIDTH-1:0]  core_out,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic [1:0]        dbg_state
);

    // Core handshake: core_start is a one-cycle pulse with core_curr/core_pre valid and held
    // until the next start; core_ready is sampled from the second WAIT cycle on, and the first
    // cycle it is seen high captures core_out for the slice in flight.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(DEPTH - 1);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("slice_stream_ctrl: TIMEOUT must be at least 1");
    end

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] k_nx;
    logic [ADDR_W-1:0] pre_idx;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wait_first;
    logic              enter_issue;
    logic              capture;
    logic              clr_ok;
    logic              wr_ok;
    logic              wr_drop;

    logic [WIDTH-1:0]  in_mem  [DEPTH];
    logic [WIDTH-1:0]  res_mem [DEPTH];

`ifdef SLICE_WATCHDOG_EN
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout;
`endif

    assign busy      = (state == S_ISSUE) || (state == S_WAIT);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    assign clr_ok  = clr && !busy;
    assign wr_ok   = wr_en && !full && !busy && !clr_ok;
    assign wr_drop = wr_en && (full || busy) && !clr_ok;

    // Previous slice of the one about to be issued, wrapping slice 0 onto the last slot.
    assign pre_idx = (k_nx == '0) ? K_LAST : k_nx - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        k_nx        = k;
        enter_issue = 1'b0;
        capture     = 1'b0;
`ifdef SLICE_WATCHDOG_EN
        timeout     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!clr && go && full) begin
                    state_nx    = S_ISSUE;
                    k_nx        = '0;
                    enter_issue = 1'b1;
                end
            end
            S_ISSUE: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!wait_first && core_ready) begin
                    capture = 1'b1;
                    if (k == K_LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx    = S_ISSUE;
                        k_nx        = k + 1'b1;
                        enter_issue = 1'b1;
                    end
                end
`ifdef SLICE_WATCHDOG_EN
                else if (wd_cnt == WD_LAST) begin
                    timeout  = 1'b1;
                    state_nx = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (clr) begin
                    state_nx = S_IDLE;
                end else if (go && full) begin
                    state_nx    = S_ISSUE;
                    k_nx        = '0;
                    enter_issue = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            wait_first <= 1'b0;
            core_start <= 1'b0;
            core_curr  <= '0;
            core_pre   <= '0;
            rd_data    <= '0;
        end else begin
            k          <= k_nx;
            wait_first <= (state == S_ISSUE);
            core_start <= enter_issue;
            if (enter_issue) begin
                core_curr <= in_mem[k_nx];
                core_pre  <= in_mem[pre_idx];
            end
            rd_data <= res_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else if (clr_ok) begin
            wr_ptr   <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == K_LAST) ? '0 : wr_ptr + 1'b1;
                if (wr_ptr == K_LAST) begin
                    full <= 1'b1;
                end
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Buffers are plain storage: contents survive reset and are only ever overwritten.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            in_mem[wr_ptr] <= wr_data;
        end
        if (capture) begin
            res_mem[k] <= core_out;
        end
    end

`ifdef SLICE_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WAIT) ? wd_cnt + 1'b1 : '0;
            if (clr_ok) begin
                err <= 1'b0;
            end else if (timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
